// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and row decode for the 3x3 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, CONFIRM, REPORT, HELD} state_e;

  localparam int         NUM_ROWS = 3;
  localparam int         NUM_COLS = 3;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef struct packed {
    logic       ghost;
    logic       any;
    logic [1:0] idx;
  } row_dec_t;

  // low is active-high here: a set bit means that row was pulled low.
  function automatic row_dec_t row_onehot_to_idx(input logic [NUM_ROWS-1:0] low);
    row_dec_t d;
    d = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (low[i]) begin
        if (d.any) begin
          d.ghost = 1'b1;
        end else begin
          d.any = 1'b1;
          d.idx = 2'(i);
        end
      end
    end
    return d;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] idx);
    logic [NUM_COLS-1:0] s;
    case (idx)
      2'd0:    s = 3'b110;
      2'd1:    s = 3'b101;
      default: s = 3'b011;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] next_col(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - prescaler producing a one-cycle scan tick every TICK_DIV clocks
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// rtl/keypad_scan_sequencer.sv - column-strobe scan FSM with press/release debounce and valid/ack key events
// Optional build macro KEYPAD_AUTOREPEAT_EN: re-report a held key every REPEAT_SCANS ticks.
module keypad_scan_sequencer
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] row,
  output logic [2:0] column,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held
);

  if (TICK_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_cfg
    $error("keypad_scan_sequencer: parameter out of range");
  end

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  logic       tick;
  logic [2:0] row_s1_q, row_s2_q;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= 3'b111;
      row_s2_q <= 3'b111;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  row_dec_t dec;
  logic     row_single;
  logic     cand_row_low;

  state_e     state_q;
  logic [1:0] col_idx_q;
  logic [3:0] cand_q;
  logic [3:0] deb_cnt_q;
  logic [3:0] rel_cnt_q;
  logic [3:0] key_q;
  logic       key_valid_q;
  logic       key_held_q;
  logic [2:0] column_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW  = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_cnt_q;
`endif

  assign dec          = row_onehot_to_idx(~row_s2_q);
  assign row_single   = dec.any && !dec.ghost;
  assign cand_row_low = ~row_s2_q[cand_q[3:2]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      cand_q      <= 4'd0;
      deb_cnt_q   <= 4'd0;
      rel_cnt_q   <= 4'd0;
      key_q       <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      column_q    <= 3'b111;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      // col_idx only moves on a tick, so the strobe lags it by exactly one cycle.
      column_q <= col_strobe(col_idx_q);
      case (state_q)
        SCAN: if (tick) begin
          if (row_single) begin
            cand_q    <= {dec.idx, col_idx_q};
            deb_cnt_q <= 4'd1;
            if (DEB == 4'd1) begin
              state_q     <= REPORT;
              key_q       <= {dec.idx, col_idx_q};
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end else begin
              state_q <= CONFIRM;
            end
          end else begin
            col_idx_q <= next_col(col_idx_q);
          end
        end
        CONFIRM: if (tick) begin
          if (row_single && dec.idx == cand_q[3:2]) begin
            deb_cnt_q <= deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB) begin
              state_q     <= REPORT;
              key_q       <= cand_q;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end
          end else begin
            state_q   <= SCAN;
            col_idx_q <= next_col(col_idx_q);
          end
        end
        REPORT: if (key_ack && key_valid_q) begin
          key_valid_q <= 1'b0;
          rel_cnt_q   <= 4'd0;
          state_q     <= HELD;
        end
        HELD: if (tick) begin
          if (!cand_row_low) begin
            if (rel_cnt_q + 4'd1 == DEB) begin
              key_q      <= KEY_NONE;
              key_held_q <= 1'b0;
              rel_cnt_q  <= 4'd0;
              state_q    <= SCAN;
              col_idx_q  <= next_col(col_idx_q);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_q  <= '0;
`endif
            end else begin
              rel_cnt_q <= rel_cnt_q + 4'd1;
            end
          end else begin
            rel_cnt_q <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_cnt_q + RW'(1) == REP) begin
              rep_cnt_q   <= '0;
              key_valid_q <= 1'b1;
              state_q     <= REPORT;
            end else begin
              rep_cnt_q <= rep_cnt_q + RW'(1);
            end
`endif
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign column    = column_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb/tb_keypad_scan_sequencer.sv - randomized self-checking bench with a behavioural keypad model
module tb_keypad_scan_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;
  localparam int MIN_LAT  = (DEB - 1) * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] row;
  logic [2:0] column;
  logic [3:0] key;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;

  logic [8:0] press_mask = 9'd0;
  int         edge_n = 0;
  int         valid_events = 0;
  logic       valid_prev = 1'b0;
  int         checks = 0;
  int         failures = 0;

  keypad_scan_sequencer #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .column    (column),
    .key       (key),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (press_mask[r*3+c] && !column[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    valid_prev <= key_valid;
    if (key_valid && !valid_prev) valid_events <= valid_events + 1;
  end

  function automatic logic [2:0] strobe(input int c);
    logic [2:0] v;
    v = 3'b111;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sample;
    step(1);
    while (edge_n % TICK_DIV != 0) step(1);
  endtask

  task automatic align_column(input int c);
    int n;
    n = 0;
    while (!(column === strobe(c) && edge_n % TICK_DIV == 1) && n < 60) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL align_column: column=%b never strobed col %0d", column, c);
    end
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (key_valid !== 1'b1 && lat < budget) begin
      step(1);
      lat++;
    end
  endtask

  task automatic wait_release(input int budget, output int lat);
    lat = 0;
    while (key_held !== 1'b0 && lat < budget) begin
      step(1);
      lat++;
    end
  endtask

  task automatic test_reset;
    press_mask = 9'd0;
    key_ack = 1'b0;
    step(7);
    reset = 1'b1;
    #2;
    checks++;
    if (column !== 3'b111 || key !== 4'hF || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: column=%b key=%h valid=%b held=%b required 111/f/0/0",
               column, key, key_valid, key_held);
    end
    step(2);
    reset = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      step(1);
      checks++;
      if (column !== strobe(((n - 1) / TICK_DIV) % 3)) begin
        failures++;
        $display("FAIL column_walk: edge %0d column=%b required %b", n, column, strobe(((n - 1) / TICK_DIV) % 3));
      end
    end
  endtask

  task automatic key_cycle(input int r, input int c, input int ack_dly);
    int lat, ev0;
    logic [3:0] exp_key;
    exp_key = 4'(r * 4 + c);
    ev0 = valid_events;
    press_mask[r*3+c] = 1'b1;
    wait_valid(48, lat);
    checks++;
    if (lat >= 48) begin
      failures++;
      $display("FAIL press_timeout: key %h never reported", exp_key);
    end
    checks++;
    if (lat < MIN_LAT) begin
      failures++;
      $display("FAIL press_latency: %0d cycles, required >= %0d", lat, MIN_LAT);
    end
    checks++;
    if (key !== exp_key || key_held !== 1'b1) begin
      failures++;
      $display("FAIL press_key: key=%h held=%b required %h/1", key, key_held, exp_key);
    end
    for (int i = 0; i < ack_dly; i++) begin
      step(1);
      checks++;
      if (key_valid !== 1'b1 || key !== exp_key) begin
        failures++;
        $display("FAIL valid_hold: valid=%b key=%h required 1/%h", key_valid, key, exp_key);
      end
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b1 || key !== exp_key) begin
      failures++;
      $display("FAIL ack: valid=%b held=%b key=%h required 0/1/%h", key_valid, key_held, key, exp_key);
    end
    step(8);
    press_mask = 9'd0;
    wait_release(40, lat);
    checks++;
    if (lat >= 40 || lat < MIN_LAT) begin
      failures++;
      $display("FAIL release_latency: %0d cycles, required %0d..39", lat, MIN_LAT);
    end
    checks++;
    if (key !== 4'hF) begin
      failures++;
      $display("FAIL release_key: key=%h required f", key);
    end
    checks++;
    if (valid_events - ev0 != 1) begin
      failures++;
      $display("FAIL event_count: %0d events, required 1", valid_events - ev0);
    end
  endtask

  task automatic test_press_ack_release;
    key_cycle(1, 1, 2);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++)
      key_cycle($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 5));
  endtask

  task automatic test_bounce;
    int r, c, ev0;
    r = $urandom_range(0, 2);
    c = $urandom_range(0, 2);
    ev0 = valid_events;
    align_column(c);
    press_mask[r*3+c] = 1'b1;
    wait_sample;
    wait_sample;
    press_mask = 9'd0;
    wait_sample;
    press_mask[r*3+c] = 1'b1;
    step(2);
    checks++;
    if (column !== strobe((c + 1) % 3)) begin
      failures++;
      $display("FAIL bounce_resume: column=%b required %b", column, strobe((c + 1) % 3));
    end
    press_mask = 9'd0;
    step(12);
    checks++;
    if (valid_events != ev0 || key !== 4'hF || key_held !== 1'b0) begin
      failures++;
      $display("FAIL bounce_event: events=%0d key=%h held=%b required 0/f/0", valid_events - ev0, key, key_held);
    end
  endtask

  task automatic test_ghost;
    int r1, r2, c, ev0;
    c  = $urandom_range(0, 2);
    r1 = $urandom_range(0, 2);
    r2 = (r1 + $urandom_range(1, 2)) % 3;
    ev0 = valid_events;
    align_column(c);
    press_mask[r1*3+c] = 1'b1;
    press_mask[r2*3+c] = 1'b1;
    wait_sample;
    step(2);
    checks++;
    if (column !== strobe((c + 1) % 3)) begin
      failures++;
      $display("FAIL ghost_advance: column=%b required %b", column, strobe((c + 1) % 3));
    end
    step(30);
    checks++;
    if (valid_events != ev0 || key !== 4'hF) begin
      failures++;
      $display("FAIL ghost_event: events=%0d key=%h required 0/f", valid_events - ev0, key);
    end
    press_mask = 9'd0;
    step(4);
  endtask

  task automatic test_release_before_ack;
    int r, c, lat, ev0;
    logic [3:0] exp_key;
    r = $urandom_range(0, 2);
    c = $urandom_range(0, 2);
    exp_key = 4'(r * 4 + c);
    ev0 = valid_events;
    press_mask[r*3+c] = 1'b1;
    wait_valid(48, lat);
    checks++;
    if (lat >= 48) begin
      failures++;
      $display("FAIL early_rel_timeout: key %h never reported", exp_key);
    end
    press_mask = 9'd0;
    step(24);
    checks++;
    if (key_valid !== 1'b1 || key !== exp_key || key_held !== 1'b1) begin
      failures++;
      $display("FAIL early_rel_hold: valid=%b key=%h held=%b required 1/%h/1", key_valid, key, key_held, exp_key);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL early_rel_ack: valid=%b held=%b required 0/1", key_valid, key_held);
    end
    wait_release(30, lat);
    checks++;
    if (lat >= 30 || lat < MIN_LAT) begin
      failures++;
      $display("FAIL early_rel_latency: %0d cycles, required %0d..29", lat, MIN_LAT);
    end
    checks++;
    if (key !== 4'hF) begin
      failures++;
      $display("FAIL early_rel_key: key=%h required f", key);
    end
    key_ack = 1'b1;
    step(6);
    key_ack = 1'b0;
    step(4);
    checks++;
    if (valid_events - ev0 != 1 || key_valid !== 1'b0 || key !== 4'hF) begin
      failures++;
      $display("FAIL stray_ack: events=%0d valid=%b key=%h required 1/0/f", valid_events - ev0, key_valid, key);
    end
  endtask

  task automatic test_repeat;
    int r, c, lat, reps, exp_reps;
    logic [3:0] exp_key;
    r = $urandom_range(0, 2);
    c = $urandom_range(0, 2);
    exp_key = 4'(r * 4 + c);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_reps = (88 / TICK_DIV) / REP;
`else
    exp_reps = 0;
`endif
    press_mask[r*3+c] = 1'b1;
    wait_valid(48, lat);
    checks++;
    if (lat >= 48) begin
      failures++;
      $display("FAIL repeat_timeout: key %h never reported", exp_key);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    reps = 0;
    for (int i = 0; i < 88; i++) begin
      step(1);
      if (key_valid === 1'b1) begin
        reps++;
        checks++;
        if (key !== exp_key) begin
          failures++;
          $display("FAIL repeat_key: key=%h required %h", key, exp_key);
        end
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        i++;
      end
    end
    checks++;
    if (reps != exp_reps) begin
      failures++;
      $display("FAIL repeat_count: %0d repeats, required %0d", reps, exp_reps);
    end
    press_mask = 9'd0;
    wait_release(40, lat);
    checks++;
    if (lat >= 40 || key !== 4'hF) begin
      failures++;
      $display("FAIL repeat_release: %0d cycles key=%h required <40/f", lat, key);
    end
  endtask

  task automatic test_reset_abort;
    int r, c, lat, ev0;
    r = $urandom_range(0, 2);
    c = $urandom_range(0, 2);
    ev0 = valid_events;
    press_mask[r*3+c] = 1'b1;
    wait_valid(48, lat);
    checks++;
    if (lat >= 48) begin
      failures++;
      $display("FAIL abort_timeout: key never reported");
    end
    reset = 1'b1;
    press_mask = 9'd0;
    #2;
    checks++;
    if (key_valid !== 1'b0 || key !== 4'hF || key_held !== 1'b0 || column !== 3'b111) begin
      failures++;
      $display("FAIL abort_state: valid=%b key=%h held=%b column=%b required 0/f/0/111",
               key_valid, key, key_held, column);
    end
    step(1);
    reset = 1'b0;
    step(40);
    checks++;
    if (valid_events - ev0 != 1 || key_valid !== 1'b0 || key !== 4'hF) begin
      failures++;
      $display("FAIL abort_rereport: events=%0d valid=%b key=%h required 1/0/f", valid_events - ev0, key_valid, key);
    end
  endtask

  initial begin
    test_reset;
    test_press_ack_release;
    test_bounce;
    test_ghost;
    test_release_before_ack;
    test_repeat;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
